// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding and the default
// RAM geometry (16 words, 4-bit address).
package prog_loader_pkg;

  localparam int LOADER_DEPTH  = 16;
  localparam int LOADER_ADDR_W = 4;

  // state   | meaning
  // IDLE    | waiting for start; all strobes low
  // LOAD    | in_ready high, waiting for a source byte
  // WRITE   | one-cycle RAM write of the captured byte
  // CHECK   | waiting for the trailing checksum byte (checksum builds only)
  // DONE    | program loaded; done held until the next start
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Program loader: streams DEPTH bytes from a valid/ready source into a RAM,
// one byte every two cycles, with abort and async active-low reset.
// Optional feature macro: LOADER_CHECKSUM_EN -- adds a CHECK state that takes
// one trailing byte and flags err when the 8-bit sum of all bytes is non-zero.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH  = LOADER_DEPTH,
  parameter int ADDR_W = LOADER_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              prg_mode,
  output logic [7:0]        prg_data,
  output logic [ADDR_W-1:0] address,
  output logic              wr_en,
  output logic              busy,
  output logic              done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic              err
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t state;
  state_t state_nxt;

  logic last_word;
  logic start_acc;
  logic byte_acc;

  assign last_word = (address == LAST_ADDR);
  // start only matters when no load is running
  assign start_acc = start && ((state == ST_IDLE) || (state == ST_DONE));
  // abort wins over a byte offered in the same cycle
  assign byte_acc  = in_valid && in_ready && !abort;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and state-derived strobes
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    prg_mode  = 1'b0;
    busy      = 1'b0;
    wr_en     = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        prg_mode = 1'b1;
        busy     = 1'b1;
        if (abort)         state_nxt = ST_IDLE;
        else if (in_valid) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        prg_mode = 1'b1;
        busy     = 1'b1;
        // an abort during the write cycle suppresses the strobe outright
        wr_en    = !abort;
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = ST_CHECK;
`else
          state_nxt = ST_DONE;
`endif
        end else begin
          state_nxt = ST_LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        // the checksum byte uses the same handshake but is never written
        in_ready = 1'b1;
        prg_mode = 1'b1;
        busy     = 1'b1;
        if (abort)         state_nxt = ST_IDLE;
        else if (in_valid) state_nxt = ST_DONE;
      end
`endif
      ST_DONE: begin
        done = 1'b1;
        if (start) state_nxt = ST_LOAD;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address counter and captured byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address  <= '0;
      prg_data <= '0;
    end else begin
      if (start_acc) begin
        address <= '0;
      end else if ((state == ST_WRITE) && !abort && !last_word) begin
        // the final word leaves the address parked at DEPTH-1
        address <= address + 1'b1;
      end
      if ((state == ST_LOAD) && byte_acc) begin
        prg_data <= in_data;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running modulo-256 sum of written bytes and the trailing-byte verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      if (start_acc) begin
        sum <= '0;
        err <= 1'b0;
      end else if ((state == ST_WRITE) && !abort) begin
        sum <= sum + prg_data;
      end else if ((state == ST_CHECK) && byte_acc) begin
        err <= ((sum + in_data) != 8'h00);
      end
    end
  end
`endif

endmodule
